mem_copy_engine: RTL and testbench

//  Memory-side initiator for the single-port data memory: owns the address/write-enable/write-data pins and consumes read data.

---
 rtl/mem_copy_pkg.sv | 14 +
 rtl/mem_copy_engine.sv | 133 +++++++++++++
 tb/tb_mem_copy_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the block-copy engine.
package mem_copy_pkg;

  localparam int unsigned W_DEF = 8;
  localparam int unsigned A_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy engine: moves len words from src to dst, one memory access per cycle,
// alternating a read cycle and a write cycle per word over a shared address pointer.
// Optional running checksum of written words: define COPY_CHECKSUM_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned A = A_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [A-1:0] src_addr,
  input  logic [A-1:0] dst_addr,
  input  logic [A:0]   len,
  output logic         busy,
  output logic         done,
  output logic [A-1:0] mem_addr,
  output logic         mem_write_en,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [W-1:0] csum
`endif
);

  copy_state_t  state, state_n;
  logic [A-1:0] src_ptr, src_ptr_n;
  logic [A-1:0] dst_ptr, dst_ptr_n;
  logic [A:0]   remaining, remaining_n;
  logic [W-1:0] hold, hold_n;
  logic         we_q;
  logic         busy_n, done_n, we_n;
  logic [A-1:0] addr_n;
  logic [W-1:0] wdata_n;
`ifdef COPY_CHECKSUM_EN
  logic [W-1:0] csum_n;
`endif

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_n     = state;
    src_ptr_n   = src_ptr;
    dst_ptr_n   = dst_ptr;
    remaining_n = remaining;
    hold_n      = hold;
`ifdef COPY_CHECKSUM_EN
    csum_n      = csum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          src_ptr_n   = src_addr;
          dst_ptr_n   = dst_addr;
          remaining_n = len;
`ifdef COPY_CHECKSUM_EN
          csum_n      = '0;
`endif
          state_n     = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        hold_n    = mem_rdata;
        src_ptr_n = src_ptr + A'(1);
        state_n   = WRITE;
      end
      WRITE: begin
        dst_ptr_n   = dst_ptr + A'(1);
        remaining_n = remaining - (A+1)'(1);
`ifdef COPY_CHECKSUM_EN
        csum_n      = csum + hold;
`endif
        state_n     = (remaining == (A+1)'(1)) ? DONE : READ;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
    we_n    = (state_n == WRITE);
    addr_n  = '0;
    wdata_n = '0;
    if (state_n == READ) begin
      addr_n = src_ptr_n;
    end else if (state_n == WRITE) begin
      addr_n  = dst_ptr_n;
      wdata_n = hold_n;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      hold      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef COPY_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_n;
      src_ptr   <= src_ptr_n;
      dst_ptr   <= dst_ptr_n;
      remaining <= remaining_n;
      hold      <= hold_n;
      busy      <= busy_n;
      done      <= done_n;
      we_q      <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
`ifdef COPY_CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

  // Reset must also kill the write already on the pins so nothing lands on the reset edge.
  assign mem_write_en = we_q & ~reset;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a behavioural memory and forward-copy model.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr, dst_addr;
  logic [8:0] len;
  logic       busy, done, mem_write_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef COPY_CHECKSUM_EN
  logic [7:0] csum;
`endif

  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  logic       poke;
  logic [7:0] poke_a, poke_d;
  logic [7:0] exp_csum;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef COPY_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  // Single-port memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (poke) mem[poke_a] <= poke_d;
    else if (mem_write_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic poke_word(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    poke = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke = 1'b0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 256; i++) gold[i] = mem[i];
  endtask

  // Reference: strict ascending word-by-word copy on the snapshot, modulo-256 addresses.
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    exp_csum = 8'h00;
    for (int i = 0; i < n; i++) begin
      gold[8'(int'(d) + i)] = gold[8'(int'(s) + i)];
      exp_csum = exp_csum + gold[8'(int'(d) + i)];
    end
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) bad++;
    check({tag, "_mem"}, 32'(bad), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_we"},    32'(mem_write_en), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // Run one copy; pulse is the cycle index (after the start edge) of an extra start, -1 for none.
  task automatic do_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                         input int n, input int pulse);
    int lat = -1, dones = 0, busyc = 0, wrs = 0;
    logic [7:0] csum_done = 8'h00;
    snapshot();
    model_copy(s, d, n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = 9'(n);
    @(posedge clk); #1;
    for (int k = 0; k <= 2 * n + 6; k++) begin
      if (k == pulse) begin
        start = 1'b1; src_addr = 8'($urandom); dst_addr = 8'($urandom);
        len = 9'($urandom_range(1, 8));
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (lat < 0) lat = k;
`ifdef COPY_CHECKSUM_EN
        csum_done = csum;
`endif
      end
      if (busy) busyc++;
      if (mem_write_en) wrs++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_lat"},    32'(lat + 1), 32'(2 * n + 1));
    check({tag, "_dones"},  32'(dones), 32'd1);
    check({tag, "_busyc"},  32'(busyc), 32'(2 * n + 1));
    check({tag, "_writes"}, 32'(wrs), 32'(n));
    compare_mem(tag);
    check_idle({tag, "_end"});
`ifdef COPY_CHECKSUM_EN
    check({tag, "_csum_done"}, 32'(csum_done), 32'(exp_csum));
    check({tag, "_csum_hold"}, 32'(csum), 32'(exp_csum));
`else
    if (csum_done != 8'h00) $display("unexpected checksum sample");
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    poke = 1'b0; poke_a = '0; poke_d = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
`ifdef COPY_CHECKSUM_EN
    check("reset_csum", 32'(csum), 32'd0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 256; i++) poke_word(8'(i), 8'($urandom));

    // Basic copy
    poke_word(8'h10, 8'hAA); poke_word(8'h11, 8'hBB);
    poke_word(8'h12, 8'hCC); poke_word(8'h13, 8'hDD);
    do_copy("basic", 8'h10, 8'h40, 4, -1);
    check("basic_w0", 32'(mem[8'h40]), 32'hAA);
    check("basic_w3", 32'(mem[8'h43]), 32'hDD);

    // Zero length
    do_copy("zero", 8'h33, 8'h77, 0, -1);

    // Wrap-around with overlap of the destination onto later source words
    poke_word(8'hFE, 8'd1); poke_word(8'hFF, 8'd2);
    poke_word(8'h00, 8'd3); poke_word(8'h01, 8'd4);
    do_copy("wrap", 8'hFE, 8'h01, 4, -1);
    check("wrap_w0", 32'(mem[8'h01]), 32'd1);
    check("wrap_w2", 32'(mem[8'h03]), 32'd3);

    // Overlap with a start pulsed while busy
    poke_word(8'h20, 8'd7);
    do_copy("overlap", 8'h20, 8'h21, 3, 2);
    check("overlap_w2", 32'(mem[8'h23]), 32'd7);

    // Start pulsed during DONE is ignored
    do_copy("done_start", 8'h05, 8'h85, 2, 4);

    // Reset during the second write
    poke_word(8'h50, 8'h11); poke_word(8'h51, 8'h22);
    poke_word(8'h52, 8'h33); poke_word(8'h53, 8'h44);
    poke_word(8'h60, 8'h00); poke_word(8'h61, 8'h00);
    poke_word(8'h62, 8'h00); poke_word(8'h63, 8'h00);
    snapshot();
    gold[8'h60] = gold[8'h50];
    @(negedge clk);
    start = 1'b1; src_addr = 8'h50; dst_addr = 8'h60; len = 9'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we_before", 32'(mem_write_en), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_we_gated", 32'(mem_write_en), 32'd0);
    @(posedge clk); #1;
    check_idle("rst_after");
    reset = 1'b0;
    @(posedge clk); #1;
    compare_mem("rst");
    do_copy("post_rst", 8'h50, 8'h60, 4, -1);

`ifdef COPY_CHECKSUM_EN
    poke_word(8'h30, 8'h80); poke_word(8'h31, 8'h90); poke_word(8'h32, 8'h10);
    do_copy("csum", 8'h30, 8'hA0, 3, -1);
    check("csum_const", 32'(csum), 32'h20);
`endif

    // Randomized copies, including a full-memory copy and a zero-length one
    for (int t = 0; t < 20; t++) begin
      int n, pulse;
      n = (t == 5) ? 256 : (t == 9) ? 0 : int'($urandom_range(1, 24));
      pulse = -1;
      if (n > 0 && ($urandom % 2) == 0) pulse = 2 * n;
      else if (n > 1) pulse = 2;
      do_copy($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom), n, pulse);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
